snake_line_renderer: RTL and testbench

//  Parametrised successor to the per-pixel snake drawer. Replaces the N-way combinational

---
 rtl/snake_line_renderer.sv | 240 ++++++++++++++++++++++++
 tb/tb_snake_line_renderer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/snake_line_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : snake_line_renderer
//  Description : Scanline renderer for the snake game. During horizontal
//                blanking an FSM walks the segment RAM one entry per cycle
//                and builds a row-occupancy bitmap (plus head column) for
//                the next line. The bitmap is double-buffered and swapped in
//                at hCount==0; during active video it drives a registered
//                12-bit rgb with head/body/fruit/background colours.
//  Ports       : clk          pixel clock, one hCount step per cycle
//                rst          asynchronous active-low reset
//                bright       active-video flag
//                hCount       current pixel column
//                vCount       current line
//                snake_length live segment count (0 = no snake)
//                fruit_x/y    fruit cell coordinates
//                seg_rd_addr  segment RAM read address (entry 0 = head)
//                seg_rd_data  {y,x} of addressed segment, 1 cycle after addr
//                rgb          registered pixel colour
//                scan_busy    FSM in CLEAR/SCAN/DRAIN
//                overrun      sticky: scan unfinished at line swap
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_line_renderer #(
  parameter int          MAX_SEG     = 128,
  parameter int          SEG_AW      = 7,
  parameter int          COORD_W     = 6,
  parameter int          CELL_LOG2   = 4,
  parameter int          GRID_W      = 40,
  parameter int          H_ACTIVE    = 640,
  parameter int          V_TOTAL     = 525,
  parameter logic [11:0] COLOR_HEAD  = 12'h0FF,
  parameter logic [11:0] COLOR_BODY  = 12'h00F,
  parameter logic [11:0] COLOR_FRUIT = 12'hF00,
  parameter logic [11:0] COLOR_BG    = 12'h0F0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bright,
  input  logic [9:0]             hCount,
  input  logic [9:0]             vCount,
  input  logic [SEG_AW:0]        snake_length,
  input  logic [COORD_W-1:0]     fruit_x,
  input  logic [COORD_W-1:0]     fruit_y,
  output logic [SEG_AW-1:0]      seg_rd_addr,
  input  logic [2*COORD_W-1:0]   seg_rd_data,
  output logic [11:0]            rgb,
  output logic                   scan_busy,
  output logic                   overrun
);

  localparam logic [SEG_AW:0]  c_max_seg  = (SEG_AW+1)'(MAX_SEG);
  localparam logic [SEG_AW:0]  c_len_one  = (SEG_AW+1)'(1);
  localparam logic [COORD_W:0] c_grid_w_x = (COORD_W+1)'(GRID_W);
  localparam logic [9:0]       c_grid_w   = 10'(GRID_W);
  localparam logic [9:0]       c_h_active = 10'(H_ACTIVE);
  localparam logic [9:0]       c_v_last   = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_SCAN  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              r_state;
  logic [SEG_AW-1:0]   r_addr;
  logic [SEG_AW:0]     r_len;
  logic [COORD_W-1:0]  r_row;
  logic                r_drain;
  logic                r_p1_v;
  logic                r_p1_head;
  logic                r_p2_v;
  logic                r_p2_head;
  logic [2*COORD_W-1:0] r_data;
  logic [GRID_W-1:0]   r_build_bmp;
  logic [COORD_W-1:0]  r_build_head_x;
  logic                r_build_head_v;
  logic [GRID_W-1:0]   r_disp_bmp;
  logic [COORD_W-1:0]  r_disp_head_x;
  logic                r_disp_head_v;
  logic                r_scan_busy;
  logic                r_overrun;
  logic [11:0]         r_rgb;

  logic                w_trigger;
  logic                w_swap;
  logic [9:0]          w_next_line;
  logic [9:0]          w_next_shift;
  logic [COORD_W-1:0]  w_target_row;
  logic [SEG_AW:0]     w_len_clamped;
  logic [COORD_W-1:0]  w_data_x;
  logic [COORD_W-1:0]  w_data_y;
  logic                w_hit;
  logic [9:0]          w_col;
  logic [9:0]          w_row;
  logic [11:0]         w_pix;

  assign w_trigger     = (hCount == c_h_active);
  assign w_swap        = (hCount == 10'd0);
  assign w_next_line   = (vCount == c_v_last) ? 10'd0 : vCount + 10'd1;
  assign w_next_shift  = w_next_line >> CELL_LOG2;
  assign w_target_row  = w_next_shift[COORD_W-1:0];
  assign w_len_clamped = (snake_length > c_max_seg) ? c_max_seg : snake_length;

  assign w_data_x = r_data[COORD_W-1:0];
  assign w_data_y = r_data[2*COORD_W-1:COORD_W];
  assign w_hit    = (w_data_y == r_row) && ({1'b0, w_data_x} < c_grid_w_x);

  // Read data is registered (r_data) before the compare, so a word is
  // consumed two cycles after its address; DRAIN therefore spans two cycles
  // and a scan occupies len+3 cycles in total.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_len          <= '0;
      r_row          <= '0;
      r_drain        <= 1'b0;
      r_p1_v         <= 1'b0;
      r_p1_head      <= 1'b0;
      r_p2_v         <= 1'b0;
      r_p2_head      <= 1'b0;
      r_data         <= '0;
      r_build_bmp    <= '0;
      r_build_head_x <= '0;
      r_build_head_v <= 1'b0;
      r_disp_bmp     <= '0;
      r_disp_head_x  <= '0;
      r_disp_head_v  <= 1'b0;
      r_scan_busy    <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_p1_v    <= 1'b0;
      r_p2_v    <= r_p1_v;
      r_p2_head <= r_p1_head;
      r_data    <= seg_rd_data;

      // Entry 0 loads the head register instead of a body bit.
      if (r_p2_v && w_hit) begin
        if (r_p2_head) begin
          r_build_head_x <= w_data_x;
          r_build_head_v <= 1'b1;
        end else begin
          r_build_bmp[w_data_x] <= 1'b1;
        end
      end

      if (w_swap) begin
        // Line swap always happens; an unfinished scan is abandoned and
        // whatever it built so far is shown.
        r_disp_bmp    <= r_build_bmp;
        r_disp_head_x <= r_build_head_x;
        r_disp_head_v <= r_build_head_v;
        if (r_state != S_IDLE) begin
          r_overrun   <= 1'b1;
          r_state     <= S_IDLE;
          r_scan_busy <= 1'b0;
          r_p2_v      <= 1'b0;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_trigger) begin
              r_state     <= S_CLEAR;
              r_scan_busy <= 1'b1;
            end
          end
          S_CLEAR: begin
            r_build_bmp    <= '0;
            r_build_head_x <= '0;
            r_build_head_v <= 1'b0;
            r_len          <= w_len_clamped;
            r_row          <= w_target_row;
            r_addr         <= '0;
            r_drain        <= 1'b0;
            r_state        <= (w_len_clamped != '0) ? S_SCAN : S_DRAIN;
          end
          S_SCAN: begin
            r_p1_v    <= 1'b1;
            r_p1_head <= (r_addr == '0);
            if ({1'b0, r_addr} == r_len - c_len_one) begin
              r_state <= S_DRAIN;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
          S_DRAIN: begin
            if (r_drain) begin
              r_state     <= S_IDLE;
              r_scan_busy <= 1'b0;
            end else begin
              r_drain <= 1'b1;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_scan_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  // Pixel path: one cycle from hCount/vCount/bright to rgb.
  assign w_col = hCount >> CELL_LOG2;
  assign w_row = vCount >> CELL_LOG2;

  always_comb begin
    w_pix = COLOR_BG;
    if (!bright) begin
      w_pix = 12'h000;
    end else if (w_col >= c_grid_w) begin
      w_pix = COLOR_BG;
    end else if (r_disp_head_v &&
                 (w_col == {{(10-COORD_W){1'b0}}, r_disp_head_x})) begin
      w_pix = COLOR_HEAD;
    end else if (r_disp_bmp[w_col[COORD_W-1:0]]) begin
      w_pix = COLOR_BODY;
    end else if ((w_col == {{(10-COORD_W){1'b0}}, fruit_x}) &&
                 (w_row == {{(10-COORD_W){1'b0}}, fruit_y})) begin
      w_pix = COLOR_FRUIT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rgb <= 12'h000;
    end else begin
      r_rgb <= w_pix;
    end
  end

  assign seg_rd_addr = r_addr;
  assign rgb         = r_rgb;
  assign scan_busy   = r_scan_busy;
  assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_snake_line_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snake_line_renderer
//  Description : Directed self-checking bench for snake_line_renderer. The
//                bench plays the timing generator (hCount/vCount/bright) and
//                a one-cycle-latency segment RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_line_renderer;

  localparam logic [11:0] c_head  = 12'h0FF;
  localparam logic [11:0] c_body  = 12'h00F;
  localparam logic [11:0] c_fruit = 12'hF00;
  localparam logic [11:0] c_bg    = 12'h0F0;

  logic        clk = 1'b0;
  logic        rst;
  logic        bright;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic [7:0]  snake_length;
  logic [5:0]  fruit_x;
  logic [5:0]  fruit_y;
  logic [6:0]  seg_rd_addr;
  logic [11:0] seg_rd_data;
  logic [11:0] rgb;
  logic        scan_busy;
  logic        overrun;

  logic [11:0] mem [0:127];
  logic [11:0] line_rgb [0:799];
  int          n_checks = 0;
  int          n_errors = 0;
  int          busy_cnt;
  int          max_addr;

  always #5 clk = ~clk;

  always @(posedge clk) seg_rd_data <= mem[seg_rd_addr];

  snake_line_renderer dut (
    .clk          (clk),
    .rst          (rst),
    .bright       (bright),
    .hCount       (hCount),
    .vCount       (vCount),
    .snake_length (snake_length),
    .fruit_x      (fruit_x),
    .fruit_y      (fruit_y),
    .seg_rd_addr  (seg_rd_addr),
    .seg_rd_data  (seg_rd_data),
    .rgb          (rgb),
    .scan_busy    (scan_busy),
    .overrun      (overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive hCount h0..h1 on line v; line_rgb[h] is rgb one edge after h.
  task automatic run_span(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) begin
      hCount = 10'(h);
      vCount = 10'(v);
      bright = (h < 640) && (v < 480);
      @(posedge clk);
      #1;
      line_rgb[h] = rgb;
      if (scan_busy) busy_cnt++;
      if (scan_busy && h > 640 && int'(seg_rd_addr) > max_addr) max_addr = int'(seg_rd_addr);
    end
  endtask

  initial begin
    rst          = 1'b0;
    bright       = 1'b0;
    hCount       = 10'd700;
    vCount       = 10'd0;
    snake_length = 8'd0;
    fruit_x      = 6'd35;
    fruit_y      = 6'd20;
    for (int i = 0; i < 128; i++) mem[i] = {6'd50, 6'd0};
    mem[0] = {6'd5, 6'd10};
    mem[1] = {6'd5, 6'd11};
    mem[2] = {6'd6, 6'd11};

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_rgb", 32'(rgb), 32'h0);
    check_eq("reset_busy", 32'(scan_busy), 32'h0);
    check_eq("reset_overrun", 32'(overrun), 32'h0);
    check_eq("reset_addr", 32'(seg_rd_addr), 32'h0);
    rst = 1'b1;

    // Reset in the middle of a scan.
    snake_length = 8'd3;
    run_span(79, 0, 645);
    check_eq("busy_before_rst", 32'(scan_busy), 32'h1);
    rst = 1'b0;
    #1;
    check_eq("midscan_rst_rgb", 32'(rgb), 32'h0);
    check_eq("midscan_rst_busy", 32'(scan_busy), 32'h0);
    check_eq("midscan_rst_overrun", 32'(overrun), 32'h0);
    #2;
    rst = 1'b1;
    run_span(80, 0, 799);
    check_eq("post_rst_col10", 32'(line_rgb[168]), 32'(c_bg));
    check_eq("post_rst_col11", 32'(line_rgb[184]), 32'(c_bg));

    // Basic render of row 5 and row 6, plus pixel latency.
    run_span(79, 0, 799);
    check_eq("hblank_rgb_zero", 32'(line_rgb[799]), 32'h0);
    run_span(80, 0, 799);
    check_eq("row5_col10_head", 32'(line_rgb[168]), 32'(c_head));
    check_eq("row5_col11_body", 32'(line_rgb[184]), 32'(c_body));
    check_eq("row5_col12_bg", 32'(line_rgb[200]), 32'(c_bg));
    check_eq("bright_rise_px0", 32'(line_rgb[0]), 32'(c_bg));
    check_eq("last_active_px", 32'(line_rgb[639]), 32'(c_bg));
    check_eq("bright_fall_px", 32'(line_rgb[640]), 32'h0);
    run_span(95, 0, 799);
    run_span(96, 0, 799);
    check_eq("row6_col11_body", 32'(line_rgb[184]), 32'(c_body));
    check_eq("row6_col10_bg", 32'(line_rgb[168]), 32'(c_bg));
    check_eq("row6_col12_bg", 32'(line_rgb[200]), 32'(c_bg));

    // Fruit under a body segment, then moved within the same line.
    mem[3]       = {6'd5, 6'd12};
    snake_length = 8'd4;
    fruit_x      = 6'd12;
    fruit_y      = 6'd5;
    run_span(79, 0, 799);
    run_span(80, 0, 203);
    check_eq("fruit_under_body", 32'(line_rgb[200]), 32'(c_body));
    fruit_x = 6'd20;
    run_span(80, 204, 799);
    check_eq("fruit_moved", 32'(line_rgb[328]), 32'(c_fruit));

    // Length clamp and zero-length scan.
    fruit_x      = 6'd35;
    fruit_y      = 6'd20;
    mem[127]     = {6'd5, 6'd30};
    snake_length = 8'd200;
    busy_cnt     = 0;
    max_addr     = 0;
    run_span(79, 0, 799);
    check_eq("clamp_busy_cycles", 32'(busy_cnt), 32'd131);
    check_eq("clamp_max_addr", 32'(max_addr), 32'd127);
    check_eq("clamp_no_overrun", 32'(overrun), 32'h0);
    run_span(80, 0, 799);
    check_eq("clamp_last_entry", 32'(line_rgb[488]), 32'(c_body));
    check_eq("clamp_head", 32'(line_rgb[168]), 32'(c_head));
    snake_length = 8'd0;
    busy_cnt     = 0;
    max_addr     = 0;
    run_span(79, 0, 799);
    check_eq("zero_len_busy", 32'(busy_cnt), 32'd3);
    check_eq("zero_len_addr", 32'(max_addr), 32'd0);
    run_span(80, 0, 799);
    check_eq("zero_len_no_head", 32'(line_rgb[168]), 32'(c_bg));

    // Overrun: line ends before a full-length scan completes.
    snake_length = 8'd200;
    run_span(79, 0, 700);
    check_eq("pre_swap_overrun", 32'(overrun), 32'h0);
    run_span(80, 0, 20);
    check_eq("overrun_set", 32'(overrun), 32'h1);
    check_eq("overrun_abort_busy", 32'(scan_busy), 32'h0);

    // Frame wrap: line 524 targets row 0.
    mem[0]       = {6'd0, 6'd7};
    mem[1]       = {6'd0, 6'd8};
    mem[2]       = {6'd29, 6'd9};
    snake_length = 8'd3;
    run_span(524, 0, 799);
    run_span(0, 0, 799);
    check_eq("wrap_row0_head", 32'(line_rgb[120]), 32'(c_head));
    check_eq("wrap_row0_body", 32'(line_rgb[136]), 32'(c_body));
    check_eq("wrap_row0_col9", 32'(line_rgb[152]), 32'(c_bg));
    check_eq("overrun_sticky", 32'(overrun), 32'h1);
    rst = 1'b0;
    #1;
    check_eq("overrun_cleared", 32'(overrun), 32'h0);
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
